// File: rtl/instr_decode_stage.sv
// Decode stage: turns raw instructions into ALU select and operand controls.
// A main entry plus a skid entry let in_ready come straight from a register.
module instr_decode_stage #(
  parameter int PC_W    = 32,
  parameter int REG_IDX = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        in_instr_i,
  input  logic [PC_W-1:0]    in_pc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [PC_W-1:0]    out_pc_o,
  output logic [4:0]         out_alu_sel_o,
  output logic [REG_IDX-1:0] out_rd_o,
  output logic [REG_IDX-1:0] out_rs1_o,
  output logic [REG_IDX-1:0] out_rs2_o,
  output logic [31:0]        out_imm_o,
  output logic               out_use_imm_o,
  output logic               out_reg_we_o,
  output logic               out_mem_re_o,
  output logic               out_mem_we_o,
  output logic               out_is_br_o,
  output logic               out_is_jal_o,
  output logic               out_illegal_o
);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [4:0]         alu_sel;
    logic [REG_IDX-1:0] rd;
    logic [REG_IDX-1:0] rs1;
    logic [REG_IDX-1:0] rs2;
    logic [31:0]        imm;
    logic               use_imm;
    logic               reg_we;
    logic               mem_re;
    logic               mem_we;
    logic               is_br;
    logic               is_jal;
    logic               illegal;
  } bundle_t;

  logic [3:0] fn, typ;
  logic       legal;
  bundle_t    dec;

  assign fn  = in_instr_i[31:28];
  assign typ = in_instr_i[27:24];

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.pc  = in_pc_i;
    dec.rd  = REG_IDX'(in_instr_i[23:20]);
    dec.rs1 = REG_IDX'(in_instr_i[19:16]);
    dec.rs2 = REG_IDX'(in_instr_i[15:12]);
    dec.imm = {{16{in_instr_i[15]}}, in_instr_i[15:0]};
    case (typ)
      4'b0000, 4'b1000: begin
        legal       = fn inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'hB, 4'hC, 4'hD, 4'hE};
        dec.alu_sel = {1'b0, fn};
        dec.reg_we  = 1'b1;
        dec.use_imm = typ[3];
      end
      4'b0010, 4'b1010: begin
        legal       = fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
        dec.alu_sel = {1'b1, fn};
        dec.reg_we  = 1'b1;
        dec.use_imm = typ[3];
      end
      4'b0110: begin
        legal       = fn inside {4'h5, 4'h6, 4'h7, 4'hD, 4'hE, 4'hF};
        dec.alu_sel = {1'b1, fn};
        dec.is_br   = 1'b1;
      end
      4'b1001: begin
        legal       = 1'b1;
        dec.use_imm = 1'b1;
        dec.mem_re  = 1'b1;
        dec.reg_we  = 1'b1;
      end
      4'b0101: begin
        legal       = 1'b1;
        dec.use_imm = 1'b1;
        dec.mem_we  = 1'b1;
      end
      4'b1011: begin
        legal       = 1'b1;
        dec.use_imm = 1'b1;
        dec.is_jal  = 1'b1;
        dec.reg_we  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Illegal bundles still flow so execute can trap, but must not side-effect.
    if (!legal) begin
      dec.alu_sel = '0;
      dec.use_imm = 1'b0;
      dec.reg_we  = 1'b0;
      dec.mem_re  = 1'b0;
      dec.mem_we  = 1'b0;
      dec.is_br   = 1'b0;
      dec.is_jal  = 1'b0;
    end
    dec.illegal = ~legal;
  end

  bundle_t m_q, m_d, s_q, s_d;
  logic    m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic    in_xfer, out_xfer;

  assign in_ready_o = ~s_valid_q;
  assign in_xfer    = in_valid_i & in_ready_o;
  assign out_xfer   = m_valid_q & out_ready_i;

  always_comb begin
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || out_xfer) begin
      // When the skid entry is full in_ready is low, so nothing arrives alongside it.
      if (s_valid_q) begin
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else begin
        m_valid_d = in_xfer;
        if (in_xfer) m_d = dec;
      end
    end else if (in_xfer) begin
      s_d       = dec;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q       <= '0;
      s_q       <= '0;
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign out_valid_o   = m_valid_q;
  assign out_pc_o      = m_q.pc;
  assign out_alu_sel_o = m_q.alu_sel;
  assign out_rd_o      = m_q.rd;
  assign out_rs1_o     = m_q.rs1;
  assign out_rs2_o     = m_q.rs2;
  assign out_imm_o     = m_q.imm;
  assign out_use_imm_o = m_q.use_imm;
  assign out_reg_we_o  = m_q.reg_we;
  assign out_mem_re_o  = m_q.mem_re;
  assign out_mem_we_o  = m_q.mem_we;
  assign out_is_br_o   = m_q.is_br;
  assign out_is_jal_o  = m_q.is_jal;
  assign out_illegal_o = m_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, backpressure, flush, reset.
module tb_instr_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [31:0] in_instr_i, in_pc_i, out_pc_o, out_imm_o;
  logic [4:0]  out_alu_sel_o;
  logic [3:0]  out_rd_o, out_rs1_o, out_rs2_o;
  logic        out_use_imm_o, out_reg_we_o, out_mem_re_o, out_mem_we_o;
  logic        out_is_br_o, out_is_jal_o, out_illegal_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] got_q[$];
  int base;

  instr_decode_stage #(.PC_W(32), .REG_IDX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_pc_i(in_pc_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_alu_sel_o(out_alu_sel_o),
    .out_rd_o(out_rd_o), .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
    .out_imm_o(out_imm_o), .out_use_imm_o(out_use_imm_o),
    .out_reg_we_o(out_reg_we_o), .out_mem_re_o(out_mem_re_o),
    .out_mem_we_o(out_mem_we_o), .out_is_br_o(out_is_br_o),
    .out_is_jal_o(out_is_jal_o), .out_illegal_o(out_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every bundle execute consumes, in order.
  always @(posedge clk_i)
    if (out_valid_o && out_ready_i) got_q.push_back(out_pc_o);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_instr_i = instr;
    in_pc_i    = pc;
    step();
    in_valid_i = 1'b0;
    check("issue_valid", out_valid_o, 1'b1);
    check("issue_pc", out_pc_o, pc);
  endtask

  // alu_sel, use_imm, reg_we, mem_re, mem_we, is_br, is_jal, illegal
  task automatic ctrl(input string tag, input logic [4:0] alu, input logic [6:0] flags);
    check(tag, {out_alu_sel_o, out_use_imm_o, out_reg_we_o, out_mem_re_o, out_mem_we_o,
                out_is_br_o, out_is_jal_o, out_illegal_o}, {alu, flags});
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    in_instr_i = '0; in_pc_i = '0;
    #12;
    check("rst_valid", out_valid_o, 1'b0);
    check("rst_ready", in_ready_o, 1'b1);
    check("rst_data", {out_pc_o, out_imm_o, out_alu_sel_o, out_rd_o}, '0);
    rst_ni = 1'b1;
    step();

    issue(32'h00312000, 32'h10);
    ctrl("add_ctrl", 5'h00, 7'b0100000);
    check("add_regs", {out_rd_o, out_rs1_o, out_rs2_o}, 12'h312);
    step();
    check("drain_valid", out_valid_o, 1'b0);

    issue(32'hB8400010, 32'h14);
    ctrl("mvhi_ctrl", 5'h0B, 7'b1100000);
    check("mvhi_imm", out_imm_o, 32'h00000010);
    step();
    issue(32'h3A12FFFF, 32'h18);
    ctrl("ltei_ctrl", 5'h13, 7'b1100000);
    check("ltei_imm", out_imm_o, 32'hFFFFFFFF);
    step();
    issue(32'h56010008, 32'h1C);
    ctrl("beqz_ctrl", 5'h15, 7'b0000100);
    step();
    issue(32'h26000000, 32'h20);
    ctrl("br_fn2_illegal", 5'h00, 7'b0000001);
    step();
    issue(32'h20000000, 32'h24);
    ctrl("alur_fn2_illegal", 5'h00, 7'b0000001);
    step();
    issue(32'h42000000, 32'h28);
    ctrl("cmpr_fn4_illegal", 5'h00, 7'b0000001);
    step();
    issue(32'h09210004, 32'h2C);
    ctrl("lw_ctrl", 5'h00, 7'b1110000);
    step();
    issue(32'h05210004, 32'h30);
    ctrl("sw_ctrl", 5'h00, 7'b1001000);
    step();
    issue(32'h0BF0FFFE, 32'h34);
    ctrl("jal_ctrl", 5'h00, 7'b1100010);
    check("jal_rd", out_rd_o, 4'hF);
    check("jal_imm", out_imm_o, 32'hFFFFFFFE);
    step();
    issue(32'h0F000000, 32'h38);
    ctrl("type_f_illegal", 5'h00, 7'b0000001);
    step();

    // Backpressure: five bundles with pcs 100..104, execute stalled for three edges.
    base = got_q.size();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_instr_i = 32'h00312000; in_pc_i = 100;
    check("bp_ready0", in_ready_o, 1'b1);
    step();
    check("bp_m_pc", out_pc_o, 100); check("bp_ready1", in_ready_o, 1'b1);
    in_pc_i = 101;
    step();
    check("bp_ready_drop", in_ready_o, 1'b0); check("bp_stable1", out_pc_o, 100);
    in_pc_i = 102;
    step();
    check("bp_ready_low", in_ready_o, 1'b0); check("bp_stable2", out_pc_o, 100);
    out_ready_i = 1'b1;
    step();
    check("bp_out101", out_pc_o, 101); check("bp_ready_back", in_ready_o, 1'b1);
    step();
    check("bp_out102", out_pc_o, 102);
    in_pc_i = 103;
    step();
    check("bp_out103", out_pc_o, 103);
    in_pc_i = 104;
    step();
    check("bp_out104", out_pc_o, 104);
    in_valid_i = 1'b0;
    step();
    check("bp_empty", out_valid_o, 1'b0);
    check("bp_count", got_q.size() - base, 5);
    for (int i = 0; i < 5 && base + i < got_q.size(); i++)
      check("bp_order", got_q[base+i], 100 + i);

    // Flush with both entries full and fetch still presenting.
    base = got_q.size();
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_pc_i = 200;
    step();
    in_pc_i = 201;
    step();
    in_pc_i = 202; flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_valid", out_valid_o, 1'b0);
    check("fl_ready", in_ready_o, 1'b1);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_quiet", out_valid_o, 1'b0);
    end
    check("fl_none_out", got_q.size() - base, 0);

    // Flush with one held bundle and one arriving into the free skid entry.
    out_ready_i = 1'b0;
    issue(32'h00312000, 32'h12C);
    in_valid_i = 1'b1; in_pc_i = 301; flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    check("fl2_valid", out_valid_o, 1'b0);
    step();
    check("fl2_quiet", out_valid_o, 1'b0);
    check("fl2_none_out", got_q.size() - base, 0);

    // Asynchronous reset mid-stream.
    out_ready_i = 1'b0;
    issue(32'hB8400010, 32'h190);
    in_valid_i = 1'b1; in_pc_i = 32'h194;
    step();
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 1'b0);
    check("mid_rst_ready", in_ready_o, 1'b1);
    check("mid_rst_alu", out_alu_sel_o, 5'h00);
    step();
    rst_ni = 1'b1; out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_quiet", out_valid_o, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
